// File: rtl/time_keeper.sv
// BCD time-of-day core: prescaled h/m/s counters, set-mode FSM with
// auto-repeating inc/dec buttons, and a 12/24-hour display mapping.
module time_keeper #(
    parameter int CLK_HZ       = 100000,
    parameter int REPEAT_DELAY = 50000,
    parameter int REPEAT_RATE  = 10000
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       mode_set,
    input  logic       inc,
    input  logic       dec,
    input  logic       fmt12,
    output logic [3:0] msb_h,
    output logic [3:0] lsb_h,
    output logic [3:0] msb_m,
    output logic [3:0] lsb_m,
    output logic [3:0] msb_s,
    output logic [3:0] lsb_s,
    output logic       pm,
    output logic       tick,
    output logic [1:0] mode_flag
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [PW-1:0] PRE_LAST    = PW'(CLK_HZ - 1);
    localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SET_S  = 2'd1,
        SET_M  = 2'd2,
        SET_H  = 2'd3
    } mode_t;

    mode_t         mode_q;
    logic [PW-1:0] pre_q;
    logic [7:0]    sec_q;
    logic [7:0]    min_q;
    logic [7:0]    hour_q;
    logic          tick_q;
    logic          mode_hist_q;

    logic          mode_press;
    logic          both_low;
    logic [1:0]    btn;
    logic [1:0]    step;

    assign btn        = {dec, inc};
    assign mode_press = !mode_set && mode_hist_q;
    assign both_low   = !inc && !dec;

    // Index 0 is inc, index 1 is dec. A button held across a mode change or
    // chorded with its partner is disarmed until it is released and re-pressed.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          hist_q;
            logic          armed_q;
            logic          armed_d;
            logic [HW-1:0] cnt_q;
            logic [HW-1:0] cnt_d;
            logic          step_c;

            always_comb begin
                cnt_d   = '0;
                armed_d = 1'b0;
                step_c  = 1'b0;
                if (btn[gi] || mode_press || both_low) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (hist_q) begin
                    armed_d = 1'b1;
                    step_c  = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b1;
                    if (cnt_q + HW'(1) == HOLD_FIRE) begin
                        step_c = 1'b1;
                        cnt_d  = HOLD_RELOAD;
                    end else begin
                        cnt_d = cnt_q + HW'(1);
                    end
                end
            end

            always_ff @(posedge clk100khz) begin
                if (rst) begin
                    hist_q  <= 1'b1;
                    armed_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    hist_q  <= btn[gi];
                    armed_q <= armed_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign step[gi] = step_c;
        end
    endgenerate

    function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00) return top;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            mode_q      <= NORMAL;
            pre_q       <= '0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            tick_q      <= 1'b0;
            mode_hist_q <= 1'b1;
        end else begin
            mode_hist_q <= mode_set;
            tick_q      <= 1'b0;
            if (mode_q == NORMAL) begin
                // A mode press beats a coincident prescaler wrap.
                if (mode_press) begin
                    mode_q <= SET_S;
                    pre_q  <= '0;
                end else if (pre_q == PRE_LAST) begin
                    pre_q  <= '0;
                    tick_q <= 1'b1;
                    sec_q  <= bcd_up(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_q <= bcd_up(min_q, 8'h59);
                        if (min_q == 8'h59) hour_q <= bcd_up(hour_q, 8'h23);
                    end
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end else begin
                pre_q <= '0;
                if (mode_press) begin
                    case (mode_q)
                        SET_S:   mode_q <= SET_M;
                        SET_M:   mode_q <= SET_H;
                        default: mode_q <= NORMAL;
                    endcase
                end else if (step[0] || step[1]) begin
                    case (mode_q)
                        SET_S:   sec_q  <= step[0] ? bcd_up(sec_q, 8'h59)  : bcd_dn(sec_q, 8'h59);
                        SET_M:   min_q  <= step[0] ? bcd_up(min_q, 8'h59)  : bcd_dn(min_q, 8'h59);
                        SET_H:   hour_q <= step[0] ? bcd_up(hour_q, 8'h23) : bcd_dn(hour_q, 8'h23);
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [4:0] hour_bin;
    logic [4:0] disp_bin;

    // 12-hour view: 0 shows as 12, 13..23 fold down by twelve.
    always_comb begin
        hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        disp_bin = hour_bin;
        if (hour_bin == 5'd0) begin
            disp_bin = 5'd12;
        end else if (hour_bin > 5'd12) begin
            disp_bin = hour_bin - 5'd12;
        end
        msb_h = hour_q[7:4];
        lsb_h = hour_q[3:0];
        if (fmt12) begin
            if (disp_bin >= 5'd10) begin
                msb_h = 4'd1;
                lsb_h = 4'(disp_bin - 5'd10);
            end else begin
                msb_h = 4'd0;
                lsb_h = disp_bin[3:0];
            end
        end
    end

    assign pm        = (hour_q >= 8'h12);
    assign msb_m     = min_q[7:4];
    assign lsb_m     = min_q[3:0];
    assign msb_s     = sec_q[7:4];
    assign lsb_s     = sec_q[3:0];
    assign tick      = tick_q;
    assign mode_flag = mode_q;
endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: constant vector table, directed corner sequences and
// random stimulus compared every cycle against a seconds-of-day model.
module tb_time_keeper;
    localparam int CLK_HZ = 10;
    localparam int RD     = 8;
    localparam int RR     = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_set;
    logic       inc;
    logic       dec;
    logic       fmt12;
    logic [3:0] msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s;
    logic       pm;
    logic       tick;
    logic [1:0] mode_flag;

    always #5 clk = ~clk;

    time_keeper #(
        .CLK_HZ      (CLK_HZ),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk100khz(clk),
        .rst      (rst),
        .mode_set (mode_set),
        .inc      (inc),
        .dec      (dec),
        .fmt12    (fmt12),
        .msb_h    (msb_h),
        .lsb_h    (lsb_h),
        .msb_m    (msb_m),
        .lsb_m    (lsb_m),
        .msb_s    (msb_s),
        .lsb_s    (lsb_s),
        .pm       (pm),
        .tick     (tick),
        .mode_flag(mode_flag)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model state
    int m_h, m_m, m_s, m_mode, m_phase, age_i, age_d;
    bit m_tick, p_ms, p_inc, p_dec;

    typedef struct {
        bit       r, ms, i, d, f;
        bit [7:0] eh, em, es;
        bit       epm;
        bit [1:0] emode;
        bit       etick;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + v % 10;
    endfunction

    function automatic int disp_hour(input int h, input bit f);
        if (!f) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_phase = 0; m_tick = 0;
        p_ms = 1; p_inc = 1; p_dec = 1; age_i = -1; age_d = -1;
    endtask

    // age = edges since the press that started the hold, -1 when not eligible
    task automatic btn_model(input bit lvl, input bit prev, input bit kill,
                             input int age_in, output int age_out, output bit st);
        st = 0;
        if (lvl || kill) begin
            age_out = -1;
        end else if (prev) begin
            age_out = 0;
            st = 1;
        end else if (age_in >= 0) begin
            age_out = age_in + 1;
            st = (age_out >= RD) && ((age_out - RD) % RR == 0);
        end else begin
            age_out = -1;
        end
    endtask

    task automatic cyc(input bit r, input bit m, input bit i, input bit d, input bit f);
        bit mp, st_i, st_d, kill;
        int tod, delta;
        rst = r; mode_set = m; inc = i; dec = d; fmt12 = f;
        @(posedge clk);
        cyc_n++;
        if (r) begin
            model_reset();
        end else begin
            mp   = !m && p_ms;
            kill = mp || (!i && !d);
            btn_model(i, p_inc, kill, age_i, age_i, st_i);
            btn_model(d, p_dec, kill, age_d, age_d, st_d);
            m_tick = 0;
            if (m_mode == 0) begin
                if (mp) begin
                    m_mode = 1;
                    m_phase = 0;
                end else if (m_phase == CLK_HZ - 1) begin
                    m_phase = 0;
                    m_tick = 1;
                    tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = tod / 3600;
                    m_m = (tod / 60) % 60;
                    m_s = tod % 60;
                end else begin
                    m_phase++;
                end
            end else begin
                m_phase = 0;
                if (mp) begin
                    m_mode = (m_mode + 1) % 4;
                end else if (st_i || st_d) begin
                    delta = st_i ? 1 : -1;
                    case (m_mode)
                        1: m_s = (m_s + delta + 60) % 60;
                        2: m_m = (m_m + delta + 60) % 60;
                        default: m_h = (m_h + delta + 24) % 24;
                    endcase
                end
            end
            p_ms = m; p_inc = i; p_dec = d;
        end
        #1;
        chk("hour", int'({msb_h, lsb_h}), to_bcd(disp_hour(m_h, f)));
        chk("min", int'({msb_m, lsb_m}), to_bcd(m_m));
        chk("sec", int'({msb_s, lsb_s}), to_bcd(m_s));
        chk("pm", int'(pm), int'(m_h >= 12));
        chk("tick", int'(tick), int'(m_tick));
        chk("mode", int'(mode_flag), m_mode);
    endtask

    task automatic do_reset();   cyc(1, 1, 1, 1, 0); endtask
    task automatic idle();       cyc(0, 1, 1, 1, 0); endtask
    task automatic press_mode(); cyc(0, 0, 1, 1, 0); idle(); endtask
    task automatic press_inc();  cyc(0, 1, 0, 1, 0); idle(); endtask
    task automatic press_dec();  cyc(0, 1, 1, 0, 0); idle(); endtask

    bit r_ms, r_i, r_d, r_f, r_rst;
    int nsteps;

    initial begin
        model_reset();
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h23, 8'h00, 8'h00, 1'b1, 2'd3, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00, 8'h00, 1'b1, 2'd3, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0};

        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].r, tbl[k].ms, tbl[k].i, tbl[k].d, tbl[k].f);
            chk("tbl_hour", int'({msb_h, lsb_h}), int'(tbl[k].eh));
            chk("tbl_min", int'({msb_m, lsb_m}), int'(tbl[k].em));
            chk("tbl_sec", int'({msb_s, lsb_s}), int'(tbl[k].es));
            chk("tbl_pm", int'(pm), int'(tbl[k].epm));
            chk("tbl_mode", int'(mode_flag), int'(tbl[k].emode));
            chk("tbl_tick", int'(tick), int'(tbl[k].etick));
        end

        // Set 23:59:58, run across midnight
        do_reset();
        press_mode(); press_dec(); press_dec();
        press_mode(); press_dec();
        press_mode(); press_dec();
        cyc(0, 0, 1, 1, 0);
        chk("a_mode", int'(mode_flag), 0);
        for (int j = 1; j <= 10; j++) idle();
        chk("a_sec59", int'({msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s}), 'h235959);
        chk("a_tick1", int'(tick), 1);
        for (int j = 1; j <= 10; j++) idle();
        chk("a_midnight", int'({msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s}), 'h000000);
        chk("a_tick2", int'(tick), 1);

        // Auto-repeat on minutes from 57
        do_reset();
        press_mode(); press_mode();
        press_dec(); press_dec(); press_dec();
        for (int j = 0; j <= 14; j++) begin
            cyc(0, 1, 0, 1, 0);
            nsteps = 1 + int'(j >= 8) + int'(j >= 11) + int'(j >= 14);
            chk("b_min", int'({msb_m, lsb_m}), to_bcd((57 + nsteps) % 60));
            chk("b_hour", int'({msb_h, lsb_h}), 'h00);
        end
        idle();

        // Hour 13 in 12-hour view
        do_reset();
        press_mode(); press_mode(); press_mode();
        for (int j = 0; j < 11; j++) press_dec();
        cyc(0, 1, 1, 1, 1);
        chk("c_disp13", int'({msb_h, lsb_h}), 'h01);
        chk("c_pm13", int'(pm), 1);

        // Mode press coincident with prescaler wrap, then chorded inc+dec
        do_reset();
        for (int j = 0; j < 9; j++) idle();
        cyc(0, 0, 1, 1, 0);
        chk("d_mode", int'(mode_flag), 1);
        chk("d_sec", int'({msb_s, lsb_s}), 'h00);
        chk("d_tick", int'(tick), 0);
        for (int j = 0; j < 20; j++) cyc(0, 1, 0, 0, 0);
        chk("d_chord", int'({msb_s, lsb_s}), 'h00);
        idle();

        // Reset in the middle of an inc hold
        do_reset();
        press_mode();
        for (int j = 0; j < 5; j++) cyc(0, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        chk("e_time", int'({msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s}), 'h000000);
        chk("e_mode", int'(mode_flag), 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        idle();
        chk("e_release", int'({msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s}), 'h000000);

        // Random stimulus against the model
        r_ms = 1; r_i = 1; r_d = 1; r_f = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) r_ms = ~r_ms;
            if ($urandom_range(0, 8) == 0) r_i = ~r_i;
            if ($urandom_range(0, 8) == 0) r_d = ~r_d;
            if ($urandom_range(0, 19) == 0) r_f = ~r_f;
            r_rst = ($urandom_range(0, 499) == 0);
            cyc(r_rst, r_ms, r_i, r_d, r_f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
